// File: rtl/exec_stage.sv
// Execute stage: operand forwarding, ALU, EX/MEM output register and an optional
// iterative shift-add multiplier enabled by defining EXEC_MUL_EN.
module exec_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [N-1:0] immediate_data,
    input  logic [N-1:0] rd1,
    input  logic [N-1:0] rd2,
    input  logic [4:0]   rs1_addr,
    input  logic [4:0]   rs2_addr,
    input  logic         alu_src,
    input  logic [3:0]   alu_operation,
    input  logic         write,
    input  logic [4:0]   write_register,
    input  logic         wb_write,
    input  logic [4:0]   wb_register,
    input  logic [N-1:0] wb_data,
    output logic         stall,
    output logic [N-1:0] alu_result_o,
    output logic [N-1:0] store_data_o,
    output logic         write_o,
    output logic [4:0]   write_register_o
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd11;

    logic [N-1:0] res_q, res_d;
    logic [N-1:0] store_q, store_d;
    logic         wr_q, wr_d;
    logic [4:0]   wreg_q, wreg_d;

    logic [N-1:0] op_a, fwd_b, op_b;
    logic [N-1:0] alu_res;
    logic         alu_ok;
    logic [4:0]   shamt;

    // Own EX/MEM register takes precedence over writeback; x0 never forwards.
    always_comb begin
        op_a = rd1;
        if (wr_q && (wreg_q != 5'd0) && (wreg_q == rs1_addr)) begin
            op_a = res_q;
        end else if (wb_write && (wb_register != 5'd0) && (wb_register == rs1_addr)) begin
            op_a = wb_data;
        end
    end

    always_comb begin
        fwd_b = rd2;
        if (wr_q && (wreg_q != 5'd0) && (wreg_q == rs2_addr)) begin
            fwd_b = res_q;
        end else if (wb_write && (wb_register != 5'd0) && (wb_register == rs2_addr)) begin
            fwd_b = wb_data;
        end
    end

    assign op_b  = alu_src ? immediate_data : fwd_b;
    assign shamt = op_b[4:0];

    // MUL is not decoded here; it resolves through the multiplier or as an invalid op.
    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (alu_operation)
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_SLL:   alu_res = op_a << shamt;
            OP_SRL:   alu_res = op_a >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_SLT:   alu_res = {{(N-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU:  alu_res = {{(N-1){1'b0}}, (op_a < op_b)};
            OP_PASSB: alu_res = op_b;
            default: begin
                alu_res = '0;
                alu_ok  = 1'b0;
            end
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(N);
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [N-1:0] mul_a_q, mul_a_d;
    logic [N-1:0] mul_b_q, mul_b_d;
    logic [N-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         mul_wr_q, mul_wr_d;
    logic [4:0]   mul_wreg_q, mul_wreg_d;
    logic [N-1:0] acc_step;
    logic         is_mul, mul_last;

    assign is_mul   = (alu_operation == OP_MUL);
    assign mul_last = (state_q == S_BUSY) && (cnt_q == CW'(N-1));
    assign acc_step = acc_q + (mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0);

    assign stall = !reset && !flush &&
                   (((state_q == S_IDLE) && is_mul) ||
                    ((state_q == S_BUSY) && (cnt_q != CW'(N-1))));

    always_comb begin
        state_d    = state_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mul_wr_d   = mul_wr_q;
        mul_wreg_d = mul_wreg_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mul) begin
                        state_d    = S_BUSY;
                        mul_a_d    = op_a;
                        mul_b_d    = op_b;
                        acc_d      = '0;
                        cnt_d      = '0;
                        mul_wr_d   = write;
                        mul_wreg_d = write_register;
                    end
                end
                S_BUSY: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                    if (mul_last) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mul_wr_q   <= 1'b0;
            mul_wreg_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mul_wr_q   <= mul_wr_d;
            mul_wreg_q <= mul_wreg_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // Bubbles clear every output field so a killed op leaves nothing forwardable.
    always_comb begin
        res_d   = alu_res;
        wr_d    = write & alu_ok;
        wreg_d  = write_register;
        store_d = fwd_b;
        if (flush) begin
            res_d   = '0;
            wr_d    = 1'b0;
            wreg_d  = 5'd0;
            store_d = '0;
        end
`ifdef EXEC_MUL_EN
        else if (state_q == S_BUSY) begin
            res_d   = '0;
            wr_d    = 1'b0;
            wreg_d  = 5'd0;
            store_d = '0;
            if (mul_last) begin
                res_d  = acc_step;
                wr_d   = mul_wr_q;
                wreg_d = mul_wreg_q;
            end
        end else if (is_mul) begin
            res_d   = '0;
            wr_d    = 1'b0;
            wreg_d  = 5'd0;
            store_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q   <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            wreg_q  <= 5'd0;
        end else begin
            res_q   <= res_d;
            store_q <= store_d;
            wr_q    <= wr_d;
            wreg_q  <= wreg_d;
        end
    end

    assign alu_result_o     = res_q;
    assign store_data_o     = store_q;
    assign write_o          = wr_q;
    assign write_register_o = wreg_q;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage; expected results flow through a scoreboard queue.
module tb_exec_stage;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset, flush;
    logic [N-1:0] immediate_data, rd1, rd2, wb_data;
    logic [4:0]   rs1_addr, rs2_addr, write_register, wb_register;
    logic         alu_src, write, wb_write;
    logic [3:0]   alu_operation;
    logic         stall;
    logic [N-1:0] alu_result_o, store_data_o;
    logic         write_o;
    logic [4:0]   write_register_o;

    typedef struct {
        logic [N-1:0] res;
        logic         wr;
        logic [4:0]   wreg;
        logic [N-1:0] store;
        bit           chk_reg;
        bit           chk_store;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exec_stage #(.N(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .immediate_data   (immediate_data),
        .rd1              (rd1),
        .rd2              (rd2),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .alu_src          (alu_src),
        .alu_operation    (alu_operation),
        .write            (write),
        .write_register   (write_register),
        .wb_write         (wb_write),
        .wb_register      (wb_register),
        .wb_data          (wb_data),
        .stall            (stall),
        .alu_result_o     (alu_result_o),
        .store_data_o     (store_data_o),
        .write_o          (write_o),
        .write_register_o (write_register_o)
    );

    task automatic set_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] imm, input logic src, input logic wr,
                          input logic [4:0] wreg);
        alu_operation  = op;
        rd1            = a;
        rd2            = b;
        immediate_data = imm;
        alu_src        = src;
        write          = wr;
        write_register = wreg;
        rs1_addr       = 5'd30;
        rs2_addr       = 5'd31;
        wb_write       = 1'b0;
        wb_register    = 5'd0;
        wb_data        = '0;
    endtask

    task automatic push_exp(input logic [N-1:0] res, input logic wr, input logic [4:0] wreg,
                            input logic [N-1:0] store, input bit creg, input bit cst);
        exp_t e;
        e.res = res; e.wr = wr; e.wreg = wreg; e.store = store;
        e.chk_reg = creg; e.chk_store = cst;
        exp_q.push_back(e);
    endtask

    task automatic push_bubble();
        push_exp('0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        set_op(4'd10, 32'h1234, 32'h5678, 32'h9, 1'b1, 1'b1, 5'd4);
        wb_write = 1'b1; wb_register = 5'd3; wb_data = 32'd77;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (alu_result_o !== '0 || store_data_o !== '0 || write_o !== 1'b0 ||
                write_register_o !== 5'd0 || stall !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got res=%h st=%h wr=%b reg=%0d stall=%b, expected all 0",
                         i, alu_result_o, store_data_o, write_o, write_register_o, stall);
            end
        end
        reset = 1'b0;
        set_op(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd1);
        push_exp(32'd12, 1'b1, 5'd1, 32'd7, 1'b1, 1'b1);
        step();
        begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (alu_result_o !== e.res || write_o !== e.wr || write_register_o !== e.wreg ||
                store_data_o !== e.store) begin
                failures++;
                $display("FAIL reset_add: got res=%h wr=%b reg=%0d st=%h, expected res=%h wr=%b reg=%0d st=%h",
                         alu_result_o, write_o, write_register_o, store_data_o, e.res, e.wr, e.wreg, e.store);
            end
        end
    endtask

    task automatic test_forwarding();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin set_op(4'd0, 32'd4, 32'd0, 32'd6, 1'b1, 1'b1, 5'd3);
                         push_exp(32'd10, 1'b1, 5'd3, 32'd0, 1'b1, 1'b1); end
                1, 3: begin set_op(4'd1, 32'd0, 32'h55, 32'd4, 1'b1, 1'b1, 5'd8);
                         rs1_addr = 5'd3; wb_write = 1'b1; wb_register = 5'd3; wb_data = 32'd99;
                         push_exp((i == 1) ? 32'd6 : 32'd95, 1'b1, 5'd8, 32'h55, 1'b1, 1'b1); end
                2: begin set_op(4'd0, 32'd4, 32'd0, 32'd6, 1'b1, 1'b1, 5'd0);
                         push_exp(32'd10, 1'b1, 5'd0, 32'd0, 1'b1, 1'b1); end
                4: begin set_op(4'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 5'd9);
                         rs2_addr = 5'd8; wb_write = 1'b1; wb_register = 5'd8; wb_data = 32'd5;
                         push_exp(32'd96, 1'b1, 5'd9, 32'd95, 1'b1, 1'b1); end
                default: begin set_op(4'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 5'd9);
                         rs2_addr = 5'd8; wb_write = 1'b1; wb_register = 5'd8; wb_data = 32'd5;
                         push_exp(32'd6, 1'b1, 5'd9, 32'd5, 1'b1, 1'b1); end
            endcase
            step();
            e = exp_q.pop_front();
            checks++;
            if (alu_result_o !== e.res || write_o !== e.wr || write_register_o !== e.wreg ||
                store_data_o !== e.store) begin
                failures++;
                $display("FAIL fwd[%0d]: got res=%h wr=%b reg=%0d st=%h, expected res=%h wr=%b reg=%0d st=%h",
                         i, alu_result_o, write_o, write_register_o, store_data_o, e.res, e.wr, e.wreg, e.store);
            end
        end
    endtask

    task automatic test_alu();
        logic [3:0]   ops [13] = '{4'd7, 4'd8, 4'd9, 4'd5, 4'd6, 4'd2, 4'd3, 4'd4, 4'd1, 4'd11, 4'd14, 4'd8, 4'd9};
        logic [N-1:0] av  [13] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                                   32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd3, 32'd0, 32'd5, 32'd1, 32'd1};
        logic [N-1:0] bv  [13] = '{32'd4, 32'd1, 32'd1, 32'd31, 32'h24, 32'hFF00, 32'hFF00, 32'hFF00,
                                   32'd5, 32'hDEAD_BEEF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [N-1:0] rv  [13] = '{32'hF800_0000, 32'd1, 32'd0, 32'h8000_0000, 32'h0800_0000, 32'hF000,
                                   32'hFFF0, 32'h0FF0, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd1};
        exp_t e;
        for (int i = 0; i < 13; i++) begin
            set_op(ops[i], av[i], bv[i], 32'd0, 1'b0, 1'b1, 5'd10);
            push_exp(rv[i], (ops[i] < 4'd12), 5'd10, bv[i], 1'b1, 1'b1);
            step();
            e = exp_q.pop_front();
            checks++;
            if (alu_result_o !== e.res || write_o !== e.wr || write_register_o !== e.wreg ||
                store_data_o !== e.store) begin
                failures++;
                $display("FAIL alu op%0d[%0d]: got res=%h wr=%b reg=%0d st=%h, expected res=%h wr=%b reg=%0d st=%h",
                         ops[i], i, alu_result_o, write_o, write_register_o, store_data_o,
                         e.res, e.wr, e.wreg, e.store);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin set_op(4'd0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 5'd5);
                         push_exp(32'd7, 1'b1, 5'd5, 32'd4, 1'b1, 1'b1); end
                1: begin set_op(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd6);
                         rs1_addr = 5'd5; rs2_addr = 5'd5;
                         push_exp(32'd14, 1'b1, 5'd6, 32'd7, 1'b1, 1'b1); end
                2: begin set_op(4'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd7);
                         rs1_addr = 5'd6; rs2_addr = 5'd5;
                         wb_write = 1'b1; wb_register = 5'd5; wb_data = 32'd7;
                         push_exp(32'd7, 1'b1, 5'd7, 32'd7, 1'b1, 1'b1); end
                default: begin set_op(4'd12, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 5'd7);
                         push_exp(32'd0, 1'b0, 5'd7, 32'd9, 1'b1, 1'b1); end
            endcase
            step();
            e = exp_q.pop_front();
            checks++;
            if (alu_result_o !== e.res || write_o !== e.wr || write_register_o !== e.wreg ||
                store_data_o !== e.store) begin
                failures++;
                $display("FAIL b2b[%0d]: got res=%h wr=%b reg=%0d st=%h, expected res=%h wr=%b reg=%0d st=%h",
                         i, alu_result_o, write_o, write_register_o, store_data_o, e.res, e.wr, e.wreg, e.store);
            end
        end
    endtask

    task automatic test_mul();
        exp_t e;
        int   stall_hi = 0;
        set_op(4'd10, 32'hFFFF_FFFF, 32'd0, 32'd3, 1'b1, 1'b1, 5'd17);
`ifdef EXEC_MUL_EN
        for (int k = 0; k < N; k++) push_bubble();
        push_exp(32'hFFFF_FFFD, 1'b1, 5'd17, '0, 1'b1, 1'b0);
        for (int k = 0; k <= N; k++) begin
            if (stall === 1'b1) stall_hi++;
            checks++;
            if (stall !== (k < N)) begin
                failures++;
                $display("FAIL mul_stall[%0d]: got %b, expected %b", k, stall, (k < N));
            end
            step();
            if (k == 0) begin
                rd1 = '0; immediate_data = '0;
                wb_write = 1'b1; wb_register = 5'd30; wb_data = '0;
            end
            e = exp_q.pop_front();
            checks++;
            if (alu_result_o !== e.res || write_o !== e.wr || (e.chk_reg && write_register_o !== e.wreg)) begin
                failures++;
                $display("FAIL mul_out[%0d]: got res=%h wr=%b reg=%0d, expected res=%h wr=%b reg=%0d",
                         k + 1, alu_result_o, write_o, write_register_o, e.res, e.wr, e.wreg);
            end
        end
        checks++;
        if (stall_hi != N) begin
            failures++;
            $display("FAIL mul_stall_count: got %0d cycles, expected %0d", stall_hi, N);
        end
`else
        push_exp(32'd0, 1'b0, 5'd17, '0, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL mul_nostall: got %b, expected 0", stall);
        end
        step();
        e = exp_q.pop_front();
        checks++;
        if (alu_result_o !== e.res || write_o !== e.wr) begin
            failures++;
            $display("FAIL mul_disabled: got res=%h wr=%b, expected res=%h wr=%b",
                     alu_result_o, write_o, e.res, e.wr);
        end
`endif
        set_op(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 5'd11);
        push_exp(32'd3, 1'b1, 5'd11, 32'd2, 1'b1, 1'b1);
        step();
        e = exp_q.pop_front();
        checks++;
        if (alu_result_o !== e.res || write_o !== e.wr || write_register_o !== e.wreg ||
            store_data_o !== e.store) begin
            failures++;
            $display("FAIL mul_next_add: got res=%h wr=%b reg=%0d st=%h, expected res=%h wr=%b reg=%0d st=%h",
                     alu_result_o, write_o, write_register_o, store_data_o, e.res, e.wr, e.wreg, e.store);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        set_op(4'd10, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 5'd12);
        for (int k = 0; k < 11; k++) push_bubble();
        for (int k = 0; k < 11; k++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if (alu_result_o !== e.res || write_o !== e.wr) begin
                failures++;
                $display("FAIL flush_pre[%0d]: got res=%h wr=%b, expected res=%h wr=%b",
                         k, alu_result_o, write_o, e.res, e.wr);
            end
        end
`ifdef EXEC_MUL_EN
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL flush_busy_stall: got %b, expected 1", stall);
        end
`endif
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall_drop: got %b, expected 0", stall);
        end
        push_bubble();
        step();
        flush = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (alu_result_o !== e.res || write_o !== e.wr) begin
            failures++;
            $display("FAIL flush_bubble: got res=%h wr=%b, expected res=%h wr=%b", alu_result_o, write_o, e.res, e.wr);
        end
        set_op(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 5'd13);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_stall: got %b, expected 0", stall);
        end
        push_exp(32'd5, 1'b1, 5'd13, 32'd3, 1'b1, 1'b1);
        step();
        e = exp_q.pop_front();
        checks++;
        if (alu_result_o !== e.res || write_o !== e.wr || write_register_o !== e.wreg) begin
            failures++;
            $display("FAIL flush_add: got res=%h wr=%b reg=%0d, expected res=%h wr=%b reg=%0d",
                     alu_result_o, write_o, write_register_o, e.res, e.wr, e.wreg);
        end
        set_op(4'd15, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 5'd13);
        for (int k = 0; k < N + 4; k++) begin
            push_bubble();
            step();
            e = exp_q.pop_front();
            checks++;
            if (alu_result_o !== e.res || write_o !== e.wr) begin
                failures++;
                $display("FAIL flush_stale[%0d]: got res=%h wr=%b, expected res=%h wr=%b",
                         k, alu_result_o, write_o, e.res, e.wr);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        exp_t e;
        set_op(4'd10, 32'd7, 32'd9, 32'd0, 1'b0, 1'b1, 5'd14);
        for (int k = 0; k < 5; k++) begin
            push_bubble();
            step();
            e = exp_q.pop_front();
            checks++;
            if (alu_result_o !== e.res || write_o !== e.wr) begin
                failures++;
                $display("FAIL rstmul_pre[%0d]: got res=%h wr=%b, expected res=%h wr=%b",
                         k, alu_result_o, write_o, e.res, e.wr);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL rstmul_stall: got %b, expected 0", stall);
        end
        step();
        checks++;
        if (alu_result_o !== '0 || store_data_o !== '0 || write_o !== 1'b0 ||
            write_register_o !== 5'd0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL rstmul_outputs: got res=%h st=%h wr=%b reg=%0d stall=%b, expected all 0",
                     alu_result_o, store_data_o, write_o, write_register_o, stall);
        end
        reset = 1'b0;
        set_op(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 5'd9);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL rstmul_idle: got stall=%b, expected 0", stall);
        end
        push_exp(32'd2, 1'b1, 5'd9, 32'd1, 1'b1, 1'b1);
        step();
        e = exp_q.pop_front();
        checks++;
        if (alu_result_o !== e.res || write_o !== e.wr || write_register_o !== e.wreg) begin
            failures++;
            $display("FAIL rstmul_add: got res=%h wr=%b reg=%0d, expected res=%h wr=%b reg=%0d",
                     alu_result_o, write_o, write_register_o, e.res, e.wr, e.wreg);
        end
        set_op(4'd15, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 5'd14);
        for (int k = 0; k < N + 4; k++) begin
            push_bubble();
            step();
            e = exp_q.pop_front();
            checks++;
            if (alu_result_o !== e.res || write_o !== e.wr) begin
                failures++;
                $display("FAIL rstmul_stale[%0d]: got res=%h wr=%b, expected res=%h wr=%b",
                         k, alu_result_o, write_o, e.res, e.wr);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_op(4'd0, '0, '0, '0, 1'b0, 1'b0, 5'd0);
        test_reset();
        test_forwarding();
        test_alu();
        test_back_to_back();
        test_mul();
        test_flush();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
